// File: rtl/am29xx_pkg.sv
// Shared constants for the am29xx microprogram sequencer slice.
// Holds the address-source encodings and default path sizes.
package am29xx_pkg;

    localparam int WIDTH_DEF = 12;
    localparam int DEPTH_DEF = 4;

    localparam logic [1:0] S_UPC = 2'b00;
    localparam logic [1:0] S_AR  = 2'b01;
    localparam logic [1:0] S_STK = 2'b10;
    localparam logic [1:0] S_D   = 2'b11;

endpackage

// File: rtl/am2911_stack.sv
// Circular subroutine stack with a saturating occupancy count.
// Pushes store the caller's return address; pops only move the pointer.
module am2911_stack
    import am29xx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             fe_,
    input  logic             pup,
    input  logic [WIDTH-1:0] push_d,
    output logic [WIDTH-1:0] top,
    output logic             stk_full,
    output logic             stk_empty
);

    localparam int SPW = $clog2(DEPTH);
    localparam int OCW = $clog2(DEPTH + 1);
    localparam logic [OCW-1:0] OCC_MAX = OCW'(DEPTH);

    logic [WIDTH-1:0] r_file [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic [OCW-1:0]   r_occ;
    logic [SPW-1:0]   w_sp_inc;
    logic [SPW-1:0]   w_sp_dec;

    assign w_sp_inc = r_sp + 1'b1;
    assign w_sp_dec = r_sp - 1'b1;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sp  <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_file[i] <= '0;
            end
        end else if (!fe_) begin
            if (pup) begin
                // When full this overwrites the oldest entry.
                r_sp           <= w_sp_inc;
                r_file[w_sp_inc] <= push_d;
                if (r_occ != OCC_MAX) begin
                    r_occ <= r_occ + 1'b1;
                end
            end else begin
                r_sp <= w_sp_dec;
                if (r_occ != '0) begin
                    r_occ <= r_occ - 1'b1;
                end
            end
        end
    end

    assign top       = r_file[r_sp];
    assign stk_full  = (r_occ == OCC_MAX);
    assign stk_empty = (r_occ == '0);

endmodule

// File: rtl/am2911_seq12.sv
// Microprogram sequencer address path: source mux, uPC, AR and loop counter.
// The stack lives in am2911_stack; y tri-states under oe_.
module am2911_seq12
    import am29xx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [1:0]       s,
    input  logic             fe_,
    input  logic             pup,
    input  logic             cntload_,
    input  logic             cnte_,
    input  logic             re_,
    input  logic             cin,
    input  logic             oe_,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y,
    output logic             ctr_zero,
    output logic             stk_full,
    output logic             stk_empty
);

    logic [WIDTH-1:0] r_upc;
    logic [WIDTH-1:0] r_ar;
    logic [WIDTH-1:0] r_ctr;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_yi;

    always_comb begin
        w_yi = r_upc;
        unique case (s)
            S_UPC: w_yi = r_upc;
            S_AR:  w_yi = r_ar;
            S_STK: w_yi = w_top;
            S_D:   w_yi = d;
        endcase
    end

    // Internal state tracks yi even while the bus is released.
    assign y = oe_ ? {WIDTH{1'bz}} : w_yi;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_upc <= '0;
            r_ar  <= '0;
            r_ctr <= '0;
        end else begin
            r_upc <= w_yi + WIDTH'(cin);
            if (!re_) begin
                r_ar <= d;
            end
            if (!cntload_) begin
                r_ctr <= d;
            end else if (!cnte_) begin
                r_ctr <= r_ctr - 1'b1;
            end
        end
    end

    assign ctr_zero = (r_ctr == '0);

    am2911_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst_     (rst_),
        .fe_      (fe_),
        .pup      (pup),
        .push_d   (r_upc),
        .top      (w_top),
        .stk_full (stk_full),
        .stk_empty(stk_empty)
    );

endmodule

// File: tb/tb_am2911_seq12.sv
// Scoreboard bench for am2911_seq12 against an arithmetic reference model.
module tb_am2911_seq12;
    import am29xx_pkg::*;

    localparam int W = 12;
    localparam int N = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 0;
    logic         rst_ = 0;
    logic [1:0]   s = S_UPC;
    logic         fe_ = 1;
    logic         pup = 0;
    logic         cntload_ = 1;
    logic         cnte_ = 1;
    logic         re_ = 1;
    logic         cin = 1;
    logic         oe_ = 0;
    logic [W-1:0] d = '0;
    wire  [W-1:0] y;
    wire          ctr_zero;
    wire          stk_full;
    wire          stk_empty;

    am2911_seq12 #(.WIDTH(W), .DEPTH(N)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .s        (s),
        .fe_      (fe_),
        .pup      (pup),
        .cntload_ (cntload_),
        .cnte_    (cnte_),
        .re_      (re_),
        .cin      (cin),
        .oe_      (oe_),
        .d        (d),
        .y        (y),
        .ctr_zero (ctr_zero),
        .stk_full (stk_full),
        .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    y;
        bit    chk_y;
        bit    cz;
        bit    full;
        bit    empty;
        string tag;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    int m_upc, m_ar, m_ctr, m_sp, m_occ;
    int m_file[N];

    function automatic void m_reset();
        m_upc = 0; m_ar = 0; m_ctr = 0; m_sp = 0; m_occ = 0;
        for (int i = 0; i < N; i++) m_file[i] = 0;
    endfunction

    task automatic check(input string tag, input string fld, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", tag, fld, act, req);
        end
    endtask

    // Monitor: compares one expectation per cycle, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_y) begin
                    n_tests++;
                    if ($isunknown(y) || int'(y) != e.y) begin
                        n_fail++;
                        $display("FAIL %s.y: got %0h, expected %0h", e.tag, y, e.y);
                    end
                end
                check(e.tag, "ctr_zero", int'(ctr_zero), int'(e.cz));
                check(e.tag, "stk_full", int'(stk_full), int'(e.full));
                check(e.tag, "stk_empty", int'(stk_empty), int'(e.empty));
            end
        end
    end

    function automatic void push_exp(input int yv, input bit cy, input string tag);
        exp_t e;
        e.y = yv;
        e.chk_y = cy;
        e.cz = (m_ctr == 0);
        e.full = (m_occ == N);
        e.empty = (m_occ == 0);
        e.tag = tag;
        q.push_back(e);
    endfunction

    task automatic cyc(input logic [1:0] ts, input int td, input logic tfe, input logic tpup,
                       input logic tcl, input logic tce, input logic tre, input logic tcin,
                       input logic toe, input string tag);
        int yi, old_upc;
        @(posedge clk);
        #2;
        s = ts; d = W'(td); fe_ = tfe; pup = tpup; cntload_ = tcl;
        cnte_ = tce; re_ = tre; cin = tcin; oe_ = toe;
        case (ts)
            S_UPC:   yi = m_upc;
            S_AR:    yi = m_ar;
            S_STK:   yi = m_file[m_sp];
            default: yi = td & MASK;
        endcase
        push_exp(yi, !toe, tag);
        old_upc = m_upc;
        m_upc = (yi + int'(tcin)) & MASK;
        if (!tre) m_ar = td & MASK;
        if (!tfe) begin
            if (tpup) begin
                m_sp = (m_sp + 1) % N;
                m_file[m_sp] = old_upc;
                if (m_occ < N) m_occ++;
            end else begin
                m_sp = (m_sp + N - 1) % N;
                if (m_occ > 0) m_occ--;
            end
        end
        if (!tcl) m_ctr = td & MASK;
        else if (!tce) m_ctr = (m_ctr + MASK) & MASK;
    endtask

    // Pulse reset between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        s = S_UPC; oe_ = 0; fe_ = 1; cntload_ = 1; cnte_ = 1; re_ = 1;
        rst_ = 0;
        #1;
        rst_ = 1;
        m_reset();
        push_exp(0, 1'b1, tag);
    endtask

    task automatic upc_idle(input string tag);
        cyc(S_UPC, 0, 1, 0, 1, 1, 1, 1, 0, tag);
    endtask

    initial begin
        m_reset();
        #12 rst_ = 1;

        do_reset("reset");

        cyc(S_D, 'h123, 1, 0, 1, 1, 1, 1, 0, "branch");
        upc_idle("seq1");
        cyc(S_UPC, 0, 1, 0, 1, 1, 1, 0, 0, "seq2_cin0");
        upc_idle("cin0_hold");

        cyc(S_D, 'h00F, 1, 0, 1, 1, 1, 1, 0, "pre_call");
        cyc(S_D, 'h200, 0, 1, 1, 1, 1, 1, 0, "call");
        upc_idle("sub1");
        upc_idle("sub2");
        cyc(S_STK, 0, 0, 0, 1, 1, 1, 1, 0, "return");
        upc_idle("after_ret");

        for (int i = 1; i <= 5; i++)
            cyc(S_D, 'h300 + i * 'h10, 0, 1, 1, 1, 1, 1, 0, $sformatf("push%0d", i));
        cyc(S_STK, 0, 1, 0, 1, 1, 1, 1, 0, "top_a5");
        for (int i = 1; i <= 5; i++)
            cyc(S_STK, 0, 0, 0, 1, 1, 1, 1, 0, $sformatf("pop%0d", i));
        upc_idle("empty_pop");

        cyc(S_UPC, 3, 1, 0, 0, 1, 1, 1, 0, "ld3");
        for (int i = 1; i <= 4; i++)
            cyc(S_UPC, 0, 1, 0, 1, 0, 1, 1, 0, $sformatf("dec%0d", i));
        cyc(S_UPC, 5, 1, 0, 0, 0, 1, 1, 0, "wrap_ld5");
        upc_idle("ld_prio");

        cyc(S_D, 'h400, 1, 0, 1, 1, 0, 1, 0, "ar_load");
        cyc(S_AR, 0, 1, 0, 1, 1, 1, 1, 1, "oe_off");
        upc_idle("oe_on");
        cyc(S_D, 'hFFF, 1, 0, 1, 1, 1, 1, 0, "wrap_top");
        upc_idle("wrap_zero");

        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 50) do_reset("rnd_reset");
            else cyc(2'($urandom_range(3)),
                     ($urandom_range(7) == 0) ? $urandom_range(2) : $urandom_range(MASK),
                     1'($urandom_range(1)), 1'($urandom_range(1)),
                     ($urandom_range(5) == 0) ? 1'b0 : 1'b1,
                     1'($urandom_range(1)), 1'($urandom_range(1)),
                     ($urandom_range(7) == 0) ? 1'b0 : 1'b1,
                     ($urandom_range(3) == 0) ? 1'b1 : 1'b0,
                     "random");
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
